// File: rtl/VX_axi_pkg.sv
// Shared AXI definitions: burst encodings, AR sideband bundle and splitter FSM states.
package VX_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam int unsigned AXI_AR_SIDE_WIDTH = 17;

  typedef struct packed {
    logic [1:0] lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi_ar_side_t;

  typedef enum logic {StIdle, StSplit} ar_state_e;

endpackage

// File: rtl/VX_fifo_queue.sv
// Small synchronous FIFO with wrap-bit pointers; full and empty are derived from the pointers.
module VX_fifo_queue #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DATAW-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  assign data_out = mem_q[rd_ptr_q[AW-1:0]];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/vx_axi_read_burst_split.sv
// Splits AXI4 read bursts into single-beat ARs for a single-beat target and regenerates RLAST
// on the in-order response stream using a FIFO of pending burst lengths.
module vx_axi_read_burst_split
  import VX_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH     = 512,
  parameter int unsigned AXI_ADDR_WIDTH     = 32,
  parameter int unsigned AXI_TID_WIDTH      = 8,
  parameter int unsigned MAX_PENDING_BURSTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [AXI_TID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic [AXI_AR_SIDE_WIDTH-1:0] s_axi_arside,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [AXI_TID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [AXI_TID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic [AXI_AR_SIDE_WIDTH-1:0] m_axi_arside,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [AXI_TID_WIDTH-1:0]     m_axi_rid,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast
);

  localparam int unsigned AW = AXI_ADDR_WIDTH;

  ar_state_e               state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              rcnt_q, rcnt_d;
  logic [AW-1:0]           base_q, base_d;
  logic [AXI_TID_WIDTH-1:0] id_q, id_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  axi_ar_side_t            side_q, side_d;

  logic       len_push, len_pop, len_empty, len_full;
  logic [7:0] len_head;
  logic       r_fire;
  logic       unused_rlast;

  logic [AW-1:0] off, mask, incr_addr;

  VX_fifo_queue #(
    .DATAW (8),
    .DEPTH (MAX_PENDING_BURSTS)
  ) u_len_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (len_push),
    .pop      (len_pop),
    .data_in  (s_axi_arlen),
    .data_out (len_head),
    .empty    (len_empty),
    .full     (len_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      base_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      base_q  <= base_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      side_q  <= side_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    side_d   = side_q;
    len_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_axi_arvalid && s_axi_arready) begin
          base_d   = s_axi_araddr;
          id_d     = s_axi_arid;
          len_d    = s_axi_arlen;
          size_d   = s_axi_arsize;
          burst_d  = s_axi_arburst;
          side_d   = axi_ar_side_t'(s_axi_arside);
          cnt_d    = '0;
          len_push = 1'b1;
          state_d  = StSplit;
        end
      end
      StSplit: begin
        if (m_axi_arready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gates arready so nothing is accepted while the FIFO is being cleared.
  always_comb begin
    s_axi_arready = (state_q == StIdle) && !len_full && !reset;
    m_axi_arvalid = (state_q == StSplit);
  end

  always_comb begin
    off       = AW'(cnt_q) << size_q;
    incr_addr = base_q + off;
    mask      = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    unique case (burst_q)
      AXI_BURST_FIXED: m_axi_araddr = base_q;
      AXI_BURST_WRAP:  m_axi_araddr = (base_q & ~mask) | (incr_addr & mask);
      default:         m_axi_araddr = incr_addr;
    endcase
  end

  assign m_axi_arid    = id_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arside  = side_q;

  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = (rcnt_q == len_head);
  assign unused_rlast = m_axi_rlast;

  assign r_fire  = s_axi_rvalid && s_axi_rready;
  assign len_pop = r_fire && s_axi_rlast;

  always_comb begin
    rcnt_d = rcnt_q;
    if (r_fire) rcnt_d = s_axi_rlast ? 8'd0 : rcnt_q + 8'd1;
  end

  // The target must never return data for a burst that was not issued.
  a_no_orphan_r: assert property (@(posedge clk) disable iff (reset) !(m_axi_rvalid && len_empty));

endmodule
